// File: rtl/vram_scanout_if.sv
// vram_scanout_if -- read-only VRAM port between the scanout engine and a
// registered-read 4K x 8 VRAM.
//   addr : 12-bit read address, driven by the scanout engine (master)
//   data : 8-bit read data, valid one clk after addr changes (slave drives)
// Reads are continuous, so there is no strobe and no write path.
interface vram_scanout_if;
  logic [11:0] addr;
  logic [7:0]  data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);
endinterface

// File: rtl/vram_scanout.sv
// vram_scanout -- 256x128 monochrome (1 bpp) raster scanout from a 4K VRAM.
// Ports:
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   pix_en      : pixel tick enable; all state advances only when high
//   vram        : VRAM read port (master): addr out, data in
//   pixel       : current pixel, 0 outside the visible region
//   hsync/vsync : sync outputs, polarity set by SYNC_ACTIVE_LOW
//   active      : high while the presented pixel is visible
//   frame_start : one-clk pulse on the tick that enters pixel (0,0)
module vram_scanout #(
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 32,
  parameter int H_BP            = 16,
  parameter int V_FP            = 8,
  parameter int V_SYNC          = 4,
  parameter int V_BP            = 20,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  vram_scanout_if.master vram,
  output logic           pixel,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic           frame_start
);

  localparam int H_ACTIVE = 256;
  localparam int V_ACTIVE = 128;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_LAST_C = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] HS_BEG_C = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END_C = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_LAST_C = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] VS_BEG_C = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END_C = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_W-1:0] h_cnt_q, h_cnt_d, h_nxt;
  logic [V_W-1:0] v_cnt_q, v_cnt_d, v_nxt;
  logic [11:0]    vram_addr_q, vram_addr_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           frame_start_q, frame_start_d;
  logic           hsync_on, vsync_on;

  // Raster position one tick ahead of the presented pixel.
  always_comb begin
    h_nxt = h_cnt_q + 1'b1;
    v_nxt = v_cnt_q;
    if (h_cnt_q == H_LAST_C) begin
      h_nxt = '0;
      v_nxt = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vram_addr_d   = vram_addr_q;
    shreg_d       = shreg_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      h_cnt_d       = h_nxt;
      v_cnt_d       = v_nxt;
      frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      // vram_addr always points at the next byte to show; the byte it
      // addresses has been on vram.data for at least 8 ticks (or the whole
      // blanking interval) by the time it is loaded.
      if ((h_nxt < H_ACT_C) && (v_nxt < V_ACT_C) && (h_nxt[2:0] == 3'd0)) begin
        shreg_d     = vram.data;
        vram_addr_d = vram_addr_q + 12'd1;
      end else begin
        shreg_d = {shreg_q[6:0], 1'b0};
      end
      // Re-align to byte 0 on vertical blank entry so a disturbed address
      // can never persist into the next frame.
      if (v_nxt == V_ACT_C) begin
        vram_addr_d = '0;
      end
    end
  end

  // Reset parks the raster in vertical blank, H_TOTAL-256 ticks before (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q       <= H_ACT_C;
      v_cnt_q       <= V_LAST_C;
      vram_addr_q   <= '0;
      shreg_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vram_addr_q   <= vram_addr_d;
      shreg_q       <= shreg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vram.addr   = vram_addr_q;
  assign frame_start = frame_start_q;
  assign active      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign pixel       = active & shreg_q[7];
  assign hsync_on    = (h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C);
  assign vsync_on    = (v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C);
  assign hsync       = (SYNC_ACTIVE_LOW != 0) ? ~hsync_on : hsync_on;
  assign vsync       = (SYNC_ACTIVE_LOW != 0) ? ~vsync_on : vsync_on;

endmodule
